// File: rtl/prog_loader.sv
// Instruction-memory loader: assembles a length-prefixed little-endian byte stream
// into 32-bit words and writes them from address 0 while holding the core in reset.
module prog_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_hold_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WR,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q;
  logic [1:0]        cnt_q;
  logic [31:0]       asm_q;
  logic [ADDR_W-3:0] idx_q;
  logic              err_q;
  logic              we_q;

  logic              xfer;
  logic [15:0]       len_full;
  logic [15:0]       idx_next;
  logic              len_bad;
  logic              len_zero;

  assign xfer     = byte_valid_i && byte_ready_o;
  assign len_full = {byte_i, len_q[7:0]};
  // Widened so idx+1 can reach MAX_WORDS without wrapping before the compare.
  assign idx_next = 16'(idx_q) + 16'd1;
  assign len_bad  = len_full > 16'(MAX_WORDS);
  assign len_zero = len_full == 16'd0;

  always_comb begin
    state_d      = state_q;
    byte_ready_o = 1'b0;
    core_hold_o  = 1'b0;
    done_o       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_LEN0;
      end
      S_LEN0: begin
        byte_ready_o = 1'b1;
        core_hold_o  = 1'b1;
        if (xfer) state_d = S_LEN1;
      end
      S_LEN1: begin
        byte_ready_o = 1'b1;
        core_hold_o  = 1'b1;
        if (xfer) state_d = (len_zero || len_bad) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        byte_ready_o = 1'b1;
        core_hold_o  = 1'b1;
        if (xfer && cnt_q == 2'd3) state_d = S_WR;
      end
      S_WR: begin
        core_hold_o = 1'b1;
        state_d     = (idx_next == len_q) ? S_DONE : S_DATA;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (start_i) state_d = S_LEN0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= (state_d == S_WR);
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            idx_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
          end
        end
        S_LEN0: begin
          if (xfer) len_q[7:0] <= byte_i;
        end
        S_LEN1: begin
          if (xfer) begin
            len_q[15:8] <= byte_i;
            cnt_q       <= '0;
            if (len_bad) err_q <= 1'b1;
          end
        end
        S_DATA: begin
          // Last byte lands in lane 3 on the edge entering WR, so the word is whole during WR.
          if (xfer) begin
            asm_q[{cnt_q, 3'b000} +: 8] <= byte_i;
            cnt_q                       <= cnt_q + 2'd1;
          end
        end
        S_WR: begin
          idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = {idx_q, 2'b00};
  assign mem_wdata_o = asm_q;
  assign err_o       = err_q;

endmodule
